// File: rtl/registered_demultiplexer.sv
// Registered demultiplexer: routes each accepted input word to one of
// N = 2**NUM_OF_CONTROL_SIGNALS output ports. Each port owns a single
// holding register (valid + data). A port can be drained and refilled in
// the same cycle, so a consumer that is always ready sees no bubbles.
module registered_demultiplexer #(
  parameter int NUM_OF_CONTROL_SIGNALS = 1,
  parameter int WIDTH                  = 1
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic [NUM_OF_CONTROL_SIGNALS-1:0]      control_signals,
  input  logic [WIDTH-1:0]                       in_data,
  input  logic                                   in_valid,
  output logic                                   in_ready,
  output logic [WIDTH-1:0]                       out_data [2**NUM_OF_CONTROL_SIGNALS-1:0],
  output logic [2**NUM_OF_CONTROL_SIGNALS-1:0]   out_valid,
  input  logic [2**NUM_OF_CONTROL_SIGNALS-1:0]   out_ready,
  output logic [NUM_OF_CONTROL_SIGNALS:0]        pending_count
);

  localparam int N = 2**NUM_OF_CONTROL_SIGNALS;

  logic [N-1:0]                    slot_valid;
  logic [N-1:0]                    slot_valid_next;
  logic [N-1:0]                    slot_load;
  logic [N-1:0]                    slot_drain;
  logic [WIDTH-1:0]                slot_data [N-1:0];
  logic [NUM_OF_CONTROL_SIGNALS:0] count_q;
  logic [NUM_OF_CONTROL_SIGNALS:0] count_next;
  logic                            accept;

  // The selected slot can take a word if it is empty or being emptied right now
  always_comb begin
    in_ready = ~slot_valid[control_signals] | out_ready[control_signals];
    accept   = in_valid & in_ready;
  end

  // Per-slot load/drain decisions and the occupancy each slot will have next cycle
  always_comb begin
    slot_load       = '0;
    slot_drain      = '0;
    slot_valid_next = '0;
    for (int i = 0; i < N; i++) begin
      slot_load[i]       = accept && (control_signals == NUM_OF_CONTROL_SIGNALS'(i));
      slot_drain[i]      = slot_valid[i] & out_ready[i];
      slot_valid_next[i] = slot_load[i] | (slot_valid[i] & ~slot_drain[i]);
    end
  end

  // Next pending count is the popcount of next occupancy, so the registered
  // count always tracks out_valid exactly, including multi-port drains
  always_comb begin
    count_next = '0;
    for (int i = 0; i < N; i++) begin
      count_next = count_next + {{NUM_OF_CONTROL_SIGNALS{1'b0}}, slot_valid_next[i]};
    end
  end

  // Holding registers and count; reset wins over any simultaneous fill or drain
  always_ff @(posedge clk) begin
    if (reset) begin
      slot_valid <= '0;
      count_q    <= '0;
      for (int i = 0; i < N; i++) begin
        slot_data[i] <= '0;
      end
    end else begin
      slot_valid <= slot_valid_next;
      count_q    <= count_next;
      for (int i = 0; i < N; i++) begin
        if (slot_load[i]) begin
          slot_data[i] <= in_data;
        end
      end
    end
  end

  assign out_valid     = slot_valid;
  assign out_data      = slot_data;
  assign pending_count = count_q;

endmodule

// File: doc/registered_demultiplexer.md
REGISTERED_DEMULTIPLEXER -- requirements
Module: registered_demultiplexer

Interface
REQ-001 SHALL have parameter NUM_OF_CONTROL_SIGNALS, default 1, number of select bits; output port count N = 2**NUM_OF_CONTROL_SIGNALS.
REQ-002 SHALL have parameter WIDTH, default 1, bits per data word.
REQ-003 SHALL have clk  input  1  sole clock; all state updates on rising edge.
REQ-004 SHALL have reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have control_signals  input  NUM_OF_CONTROL_SIGNALS  destination port index for the current input word.
REQ-006 SHALL have in_data  input  WIDTH  input word.
REQ-007 SHALL have in_valid  input  1  in_data/control_signals valid this cycle.
REQ-008 SHALL have in_ready  output  1  block can accept the presented word this cycle.
REQ-009 SHALL have out_data  output  unpacked array [N-1:0] of WIDTH  per-port registered word.
REQ-010 SHALL have out_valid  output  N  per-port word-held flag.
REQ-011 SHALL have out_ready  input  N  per-port consumer accept.
REQ-012 SHALL have pending_count  output  NUM_OF_CONTROL_SIGNALS+1  number of ports currently holding a word.

Function
REQ-013 SHALL contain one holding register (valid bit + WIDTH data) per output port; out_data[i]/out_valid[i] driven directly from slot i.
REQ-014 Transfer in: accept when in_valid & in_ready; in_ready = ~out_valid[control_signals] | out_ready[control_signals] (combinational, depends only on selected port).
REQ-015 Transfer out on port i: out_valid[i] & out_ready[i]; slot i cleared next cycle unless refilled same cycle.
REQ-016 Latency: accepted word SHALL appear on out_data[sel]/out_valid[sel] exactly 1 cycle after acceptance.
REQ-017 Simultaneous drain and fill of same port: slot SHALL load the new word, out_valid stays 1, no bubble.
REQ-018 Non-selected ports SHALL keep their words unchanged; words never duplicated, dropped, or reordered per port.
REQ-019 out_data[i] SHALL hold its value while out_valid[i]=1 and out_ready[i]=0; when out_valid[i]=0 out_data[i] retains last value.
REQ-020 Selected port full and not draining: in_ready=0, no state change on that port; other ports may still drain.
REQ-021 in_valid=0: in_ready still reflects selected port; no load.
REQ-022 pending_count SHALL be registered and equal popcount(out_valid) every cycle; max value N fits width without wrap.
REQ-023 Per cycle pending_count SHALL change by +1 (fill only), -1 per drained port not refilled, net of both; multiple ports may drain in one cycle.
REQ-024 Control_signals/in_data when in_valid=0 SHALL have no effect.

Reset
REQ-025 While reset=1 at a clock edge: all out_valid=0, all out_data=0, pending_count=0; in_valid ignored.
REQ-026 Reset mid-operation SHALL discard all held words; first accept SHALL be possible the cycle after reset deasserts (in_ready=1 then).
REQ-027 Reset SHALL take priority over simultaneous fill and drain.

Verification (NUM_OF_CONTROL_SIGNALS=2, WIDTH=8)
REQ-028 Reset, then in_valid=1, sel=2, data=0xA5, out_ready=0 -> next cycle out_valid=4'b0100, out_data[2]=0xA5, pending_count=1.
REQ-029 Port 2 full, out_ready=0, present sel=2 data=0x3C -> in_ready=0; out_data[2] stays 0xA5 for 5 cycles; then out_ready[2]=1 same cycle -> in_ready=1, next cycle out_data[2]=0x3C, out_valid[2]=1, count=1.
REQ-030 Fill ports 0..3 with 0x10,0x11,0x12,0x13 on 4 consecutive cycles, out_ready=0 -> pending_count=4, out_valid=4'b1111; then out_ready=4'b1111 one cycle -> out_valid=0, count=0.
REQ-031 Port 1 full, present sel=3 data=0x77 with out_ready=0 -> accepted, port 1 unchanged, count 1->2.
REQ-032 Ports 0,1 full, assert reset one cycle with in_valid=1 sel=0 -> out_valid=0, out_data all 0x00, count=0; cycle after, in_ready=1.
REQ-033 Random stimulus 10k cycles, random in_valid/out_ready -> per-port scoreboard: every accepted word delivered once, in order; count equals popcount(out_valid) each cycle.
